// File: rtl/kmeans_pkg.sv
// Shared constants, derived widths and FSM state type for the K-means iteration controller.
// The watchdog limit KM_TIMEOUT_CYCLES is only used when KMEANS_TIMEOUT_EN is defined.
package kmeans_pkg;

  localparam int KM_N_POINTS       = 512;
  localparam int KM_N_CLUSTERS     = 8;
  localparam int KM_N_DIMS         = 7;
  localparam int KM_DATA_W         = 13;
  localparam int KM_TIMEOUT_CYCLES = 4096;

  localparam int KM_ADDR_W = $clog2(KM_N_POINTS);
  localparam int KM_IDX_W  = $clog2(KM_N_CLUSTERS);
  localparam int KM_CNT_W  = $clog2(KM_N_POINTS) + 1;
  localparam int KM_ITER_W = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ASSIGN,
    S_DRAIN,
    S_UPDATE,
    S_CHECK,
    S_DONE
  } km_state_t;

endpackage

// File: rtl/kmeans_cluster_counter.sv
// Per-cluster membership counters: synchronous clear, increment by index, one read port.
`default_nettype none

module kmeans_cluster_counter
  import kmeans_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                i_clr,
  input  logic                i_inc,
  input  logic [KM_IDX_W-1:0] i_inc_idx,
  input  logic [KM_IDX_W-1:0] i_rd_idx,
  output logic [KM_CNT_W-1:0] o_rd_cnt
);

  logic [KM_CNT_W-1:0] r_cnt [KM_N_CLUSTERS];

  // Count one assignment per cycle into the selected cluster; clear wins over increment.
  // NOTE: this array is small and its reset value is architecturally visible, so it is
  // reset like ordinary flops; large storage arrays would normally be left unreset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < KM_N_CLUSTERS; i++) r_cnt[i] <= '0;
    end else if (i_clr) begin
      for (int i = 0; i < KM_N_CLUSTERS; i++) r_cnt[i] <= '0;
    end else if (i_inc) begin
      r_cnt[i_inc_idx] <= r_cnt[i_inc_idx] + 1'b1;
    end
  end

  assign o_rd_cnt = r_cnt[i_rd_idx];

endmodule

`default_nettype wire

// File: rtl/kmeans_iter_ctrl.sv
// K-means run sequencer: clear -> stream points -> drain -> per-centroid divide -> convergence check.
// Optional watchdog: define KMEANS_TIMEOUT_EN to abort a stalled run with timeout_err.
`default_nettype none

module kmeans_iter_ctrl
  import kmeans_pkg::*;
#(
  parameter int MAX_ITER        = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 go,
  output logic                 busy,
  output logic                 done,
  output logic                 converged,
  output logic [KM_ITER_W-1:0] iter_count,
  output logic                 acc_clr,
  output logic                 pt_req,
  output logic [KM_ADDR_W-1:0] pt_addr,
  input  logic                 pt_ack,
  input  logic                 asg_valid,
  input  logic [KM_IDX_W-1:0]  asg_cluster,
  output logic                 div_start,
  output logic [KM_IDX_W-1:0]  div_idx,
  output logic [KM_CNT_W-1:0]  div_count,
  input  logic                 div_done,
  output logic                 chk_start,
  input  logic                 chk_valid,
  input  logic                 chk_moved,
  output logic                 timeout_err
);

  localparam int                   OUT_W     = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OUT_W-1:0]     OUT_MAX   = OUT_W'(MAX_OUTSTANDING);
  localparam logic [KM_ADDR_W-1:0] ADDR_LAST = KM_ADDR_W'(KM_N_POINTS - 1);
  localparam logic [KM_IDX_W-1:0]  IDX_LAST  = KM_IDX_W'(KM_N_CLUSTERS - 1);
  localparam logic [KM_ITER_W-1:0] ITER_LAST = KM_ITER_W'(MAX_ITER - 1);

  km_state_t            r_state;
  logic                 r_busy, r_done, r_converged, r_acc_clr;
  logic                 r_pt_req, r_div_start, r_chk_start, r_div_wait;
  logic [KM_ITER_W-1:0] r_iter_count;
  logic [KM_ADDR_W-1:0] r_pt_addr;
  logic [KM_IDX_W-1:0]  r_div_idx;
  logic [KM_CNT_W-1:0]  r_div_count;
  logic [OUT_W-1:0]     r_outstanding;

  logic                 w_hs, w_asg, w_div_adv, w_timeout;
  logic [OUT_W-1:0]     w_out_next;
  logic [KM_CNT_W-1:0]  w_rd_cnt;

  // An assignment with nothing in flight is a datapath protocol error and is dropped.
  assign w_hs       = r_pt_req && pt_ack;
  assign w_asg      = asg_valid && (r_state != S_IDLE) && (r_outstanding != '0);
  assign w_out_next = r_outstanding + OUT_W'(w_hs) - OUT_W'(w_asg);
  // Empty clusters keep their old centroid and cost one cycle; others wait for div_done.
  assign w_div_adv  = r_div_wait ? div_done : (w_rd_cnt == '0);

  kmeans_cluster_counter u_counter (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (r_state == S_CLEAR),
    .i_inc     (w_asg),
    .i_inc_idx (asg_cluster),
    .i_rd_idx  (r_div_idx),
    .o_rd_cnt  (w_rd_cnt)
  );

  // Main sequencer; every output is a flop so the datapath sees glitch-free controls.
  // NOTE: all state here uses non-blocking assignment so every branch reads the
  // pre-edge values, regardless of statement order inside the block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_converged   <= 1'b0;
      r_acc_clr     <= 1'b0;
      r_pt_req      <= 1'b0;
      r_div_start   <= 1'b0;
      r_chk_start   <= 1'b0;
      r_div_wait    <= 1'b0;
      r_iter_count  <= '0;
      r_pt_addr     <= '0;
      r_div_idx     <= '0;
      r_div_count   <= '0;
      r_outstanding <= '0;
    end else begin
      r_acc_clr     <= 1'b0;
      r_div_start   <= 1'b0;
      r_chk_start   <= 1'b0;
      r_done        <= 1'b0;
      r_outstanding <= w_out_next;
      if (w_timeout) begin
        r_state     <= S_DONE;
        r_done      <= 1'b1;
        r_converged <= 1'b0;
        r_pt_req    <= 1'b0;
        r_div_wait  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: if (go) begin
            r_state      <= S_CLEAR;
            r_busy       <= 1'b1;
            r_iter_count <= '0;
            r_converged  <= 1'b0;
            r_acc_clr    <= 1'b1;
          end
          S_CLEAR: begin
            r_pt_addr     <= '0;
            r_outstanding <= '0;
            r_pt_req      <= 1'b1;
            r_state       <= S_ASSIGN;
          end
          S_ASSIGN: begin
            if (w_hs) r_pt_addr <= r_pt_addr + 1'b1;
            if (w_hs && (r_pt_addr == ADDR_LAST)) begin
              r_pt_req <= 1'b0;
              r_state  <= S_DRAIN;
            end else begin
              r_pt_req <= (w_out_next < OUT_MAX);
            end
          end
          S_DRAIN: if (r_outstanding == '0) begin
            r_state    <= S_UPDATE;
            r_div_idx  <= '0;
            r_div_wait <= 1'b0;
          end
          S_UPDATE: begin
            if (!r_div_wait && (w_rd_cnt != '0)) begin
              r_div_start <= 1'b1;
              r_div_count <= w_rd_cnt;
              r_div_wait  <= 1'b1;
            end
            if (w_div_adv) begin
              r_div_wait <= 1'b0;
              if (r_div_idx == IDX_LAST) begin
                r_state     <= S_CHECK;
                r_chk_start <= 1'b1;
              end else begin
                r_div_idx <= r_div_idx + 1'b1;
              end
            end
          end
          S_CHECK: if (chk_valid) begin
            r_iter_count <= r_iter_count + 1'b1;
            if (!chk_moved || (r_iter_count == ITER_LAST)) begin
              r_state     <= S_DONE;
              r_done      <= 1'b1;
              r_converged <= !chk_moved;
            end else begin
              r_state   <= S_CLEAR;
              r_acc_clr <= 1'b1;
            end
          end
          S_DONE: begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef KMEANS_TIMEOUT_EN
  localparam int              WD_W     = $clog2(KM_TIMEOUT_CYCLES) + 1;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(KM_TIMEOUT_CYCLES - 1);

  km_state_t       r_state_q;
  logic [WD_W-1:0] r_wd_cnt;
  logic            r_timeout_err;
  logic            w_wd_kick, w_wd_watch;

  // Any progress (state change or datapath handshake) restarts the watchdog.
  assign w_wd_kick  = (r_state != r_state_q) || w_hs || w_asg ||
                      (r_div_wait && div_done) || ((r_state == S_CHECK) && chk_valid);
  assign w_wd_watch = r_state inside {S_ASSIGN, S_DRAIN, S_UPDATE, S_CHECK};
  assign w_timeout  = w_wd_watch && !w_wd_kick && (r_wd_cnt == WD_LIMIT);

  // Saturating cycles-since-progress counter and sticky error flag (cleared only by rst).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q     <= S_IDLE;
      r_wd_cnt      <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state_q <= r_state;
      if (w_wd_kick)              r_wd_cnt <= '0;
      else if (r_wd_cnt != WD_LIMIT) r_wd_cnt <= r_wd_cnt + 1'b1;
      if (w_timeout) r_timeout_err <= 1'b1;
    end
  end

  assign timeout_err = r_timeout_err;
`else
  assign w_timeout   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign busy       = r_busy;
  assign done       = r_done;
  assign converged  = r_converged;
  assign iter_count = r_iter_count;
  assign acc_clr    = r_acc_clr;
  assign pt_req     = r_pt_req;
  assign pt_addr    = r_pt_addr;
  assign div_start  = r_div_start;
  assign div_idx    = r_div_idx;
  assign div_count  = r_div_count;
  assign chk_start  = r_chk_start;

endmodule

`default_nettype wire

// File: tb/tb_kmeans_iter_ctrl.sv
// Directed bench for kmeans_iter_ctrl with a behavioural datapath responder and a
// scoreboard of expected divide requests. Watchdog case runs when KMEANS_TIMEOUT_EN is defined.
module tb_kmeans_iter_ctrl;
  import kmeans_pkg::*;

  logic       clk = 1'b0;
  logic       rst, go;
  logic       busy, done, converged, acc_clr, pt_req, pt_ack, asg_valid;
  logic [4:0] iter_count;
  logic [8:0] pt_addr;
  logic [2:0] asg_cluster, div_idx;
  logic [9:0] div_count;
  logic       div_start, div_done, chk_start, chk_valid, chk_moved, timeout_err;

  always #5 clk = ~clk;

  kmeans_iter_ctrl #(.MAX_ITER(16), .MAX_OUTSTANDING(4)) u_dut (
    .clk(clk), .rst(rst), .go(go), .busy(busy), .done(done), .converged(converged),
    .iter_count(iter_count), .acc_clr(acc_clr), .pt_req(pt_req), .pt_addr(pt_addr),
    .pt_ack(pt_ack), .asg_valid(asg_valid), .asg_cluster(asg_cluster),
    .div_start(div_start), .div_idx(div_idx), .div_count(div_count), .div_done(div_done),
    .chk_start(chk_start), .chk_valid(chk_valid), .chk_moved(chk_moved),
    .timeout_err(timeout_err)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  typedef struct { int idx; int cnt; } div_exp_t;
  typedef struct { int cl;  int due; } asg_t;
  div_exp_t sb[$];
  asg_t     pend[$];

  // Directed-step knobs for the datapath responder
  bit rand_mode = 0, moved_mode = 0, all3_mode = 0, hold_div = 0;
  int exp_chk_delta = -1;

  // Responder bookkeeping
  int cyc = 0, exp_addr = 0, hs_cnt = 0, acc_cnt = 0, div_cnt = 0, chk_cnt = 0;
  int m_out = 0, max_out = 0, lat = 0, prev_addr = 0;
  int div_due = -1, chk_due = -1, last_dd = 0;
  bit prev_req = 0, prev_ack = 0;
  div_exp_t e;

  // Datapath model: decides inputs at negedge for the following posedge and checks traffic.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      pt_ack = 0; asg_valid = 0; asg_cluster = 0; div_done = 0;
      chk_valid = 0; chk_moved = 0; pend.delete();
      m_out = 0; exp_addr = 0; prev_req = 0; prev_ack = 0; div_due = -1; chk_due = -1;
    end else begin
      if (prev_req && !prev_ack) begin
        check("req_hold", 32'(pt_req), 32'd1);
        check("addr_hold", 32'(pt_addr), 32'(prev_addr));
      end
      if (acc_clr) begin
        acc_cnt++;
        exp_addr = 0;
      end
      asg_valid = 0;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        asg_valid   = 1;
        asg_cluster = 3'(pend[0].cl);
        void'(pend.pop_front());
        m_out--;
      end
      pt_ack = rand_mode ? ($urandom_range(0, 99) < 30) : 1'b1;
      if (pt_req && pt_ack) begin
        check("pt_addr", 32'(pt_addr), 32'(exp_addr));
        exp_addr++;
        hs_cnt++;
        m_out++;
        lat = rand_mode ? int'($urandom_range(1, 10)) : 2;
        pend.push_back('{all3_mode ? 3 : int'(pt_addr) % 8, cyc + lat});
      end
      if (m_out > max_out) max_out = m_out;
      prev_req  = pt_req;
      prev_ack  = pt_ack;
      prev_addr = int'(pt_addr);
      if (div_start) begin
        div_cnt++;
        check("div_expected", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("div_idx", 32'(div_idx), 32'(e.idx));
          check("div_count", 32'(div_count), 32'(e.cnt));
        end
        if (!hold_div) div_due = cyc + 3;
      end
      div_done = (div_due == cyc);
      if (div_done) last_dd = cyc;
      if (chk_start) begin
        chk_cnt++;
        if (exp_chk_delta >= 0) check("upd_cycles", 32'(cyc - last_dd), 32'(exp_chk_delta));
        chk_due = cyc + 2;
      end
      chk_valid = (chk_due == cyc);
      chk_moved = moved_mode;
    end
  end

  task automatic clear_stats();
    hs_cnt = 0; acc_cnt = 0; div_cnt = 0; chk_cnt = 0; max_out = 0;
  endtask

  task automatic push_even(input int passes);
    for (int p = 0; p < passes; p++)
      for (int i = 0; i < 8; i++) sb.push_back('{i, 64});
  endtask

  task automatic start_run();
    @(negedge clk) go = 1;
    @(negedge clk) go = 0;
    check("busy_after_go", 32'(busy), 32'd1);
    check("acc_clr_on_clear", 32'(acc_clr), 32'd1);
  endtask

  task automatic finish_run(input string tag, input int exp_conv, input int exp_iter);
    bit ok = 0;
    for (int n = 0; n < 20000 && !ok; n++) begin
      @(negedge clk);
      if (done) ok = 1;
    end
    check({tag, "_done_seen"}, 32'(ok), 32'd1);
    check({tag, "_converged"}, 32'(converged), 32'(exp_conv));
    check({tag, "_iter_count"}, 32'(iter_count), 32'(exp_iter));
    check({tag, "_busy_in_done"}, 32'(busy), 32'd1);
    @(negedge clk);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    check({tag, "_iter_hold"}, 32'(iter_count), 32'(exp_iter));
    check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_converged"}, 32'(converged), 32'd0);
    check({tag, "_acc_clr"}, 32'(acc_clr), 32'd0);
    check({tag, "_pt_req"}, 32'(pt_req), 32'd0);
    check({tag, "_pt_addr"}, 32'(pt_addr), 32'd0);
    check({tag, "_iter_count"}, 32'(iter_count), 32'd0);
    check({tag, "_div_start"}, 32'(div_start), 32'd0);
    check({tag, "_div_idx"}, 32'(div_idx), 32'd0);
    check({tag, "_div_count"}, 32'(div_count), 32'd0);
    check({tag, "_chk_start"}, 32'(chk_start), 32'd0);
    check({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
  endtask

  initial begin
    bit hit;
    rst = 1; go = 0;
    repeat (3) @(negedge clk);
    check_reset_values("rst");
    @(negedge clk) rst = 0;

    // A: round-robin clusters, converges after the first check
    clear_stats(); exp_chk_delta = 1; push_even(1);
    start_run();
    finish_run("A", 1, 1);
    check("A_handshakes", 32'(hs_cnt), 32'd512);
    check("A_acc_clr", 32'(acc_cnt), 32'd1);
    check("A_div_starts", 32'(div_cnt), 32'd8);
    check("A_checks", 32'(chk_cnt), 32'd1);

    // B: centroids always move, run stops at the iteration cap
    clear_stats(); moved_mode = 1; push_even(16);
    start_run();
    finish_run("B", 0, 16);
    check("B_handshakes", 32'(hs_cnt), 32'd8192);
    check("B_acc_clr", 32'(acc_cnt), 32'd16);
    check("B_div_starts", 32'(div_cnt), 32'd128);

    // C: every point lands in cluster 3; seven empty clusters are skipped
    clear_stats(); moved_mode = 0; all3_mode = 1; exp_chk_delta = 5;
    sb.push_back('{3, 512});
    start_run();
    finish_run("C", 1, 1);
    check("C_div_starts", 32'(div_cnt), 32'd1);

    // D: sparse pt_ack and random assignment latency
    clear_stats(); all3_mode = 0; rand_mode = 1; exp_chk_delta = 1; push_even(1);
    start_run();
    finish_run("D", 1, 1);
    check("D_handshakes", 32'(hs_cnt), 32'd512);
    check("D_max_outstanding_le4", 32'(max_out <= 4), 32'd1);

    // E: reset in the middle of ASSIGN, then a clean restart
    clear_stats(); rand_mode = 0;
    start_run();
    hit = 0;
    for (int n = 0; n < 2000 && !hit; n++) begin
      @(negedge clk);
      if (pt_req && pt_addr == 9'd200) hit = 1;
    end
    check("E_reached_addr200", 32'(hit), 32'd1);
    rst = 1;
    @(posedge clk); #1;
    check_reset_values("E_midrst");
    @(negedge clk) rst = 0;
    @(negedge clk);
    clear_stats(); push_even(1);
    start_run();
    finish_run("E", 1, 1);
    check("E_handshakes", 32'(hs_cnt), 32'd512);

`ifdef KMEANS_TIMEOUT_EN
    // F: divider never answers; watchdog aborts the run
    clear_stats(); hold_div = 1; exp_chk_delta = -1;
    sb.push_back('{0, 64});
    start_run();
    finish_run("F", 0, 0);
    check("F_timeout_err", 32'(timeout_err), 32'd1);
    check("F_div_starts", 32'(div_cnt), 32'd1);
    check("F_checks", 32'(chk_cnt), 32'd0);
`else
    check("timeout_err_tied", 32'(timeout_err), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_watchdog: observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
